encoder83_pend: RTL

Registered 8-to-3 priority encoder that turns eight request lines into a 3-bit index with a valid/acknowledge handshake; it is the encode direction of the 3-to-8 decoder path. Request assertions are edge-captured into a pending register so that short pulses are never lost. The block sits between a bank of request or select sources and the consumer that dispatches on a 3-bit index.

---
 rtl/encoder83_pend_pkg.sv | 20 ++
 rtl/encoder83_pend_prio.sv | 28 ++
 rtl/encoder83_pend.sv | 121 ++++++++++++
 3 files changed

// File: rtl/encoder83_pend_pkg.sv
// Shared types and helpers for the registered 8-to-3 pending encoder.
// Optional feature macro: ENCODER83_PEND_ROUND_ROBIN_EN.
package encoder83_pkg;

    localparam int REQ_W = 8;
    localparam int SEL_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    function automatic logic [REQ_W-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [REQ_W-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/encoder83_pend_prio.sv
// Combinational priority search over 8 bits starting at a rotating index.
// A start of 0 gives plain lowest-index-wins priority.
module prio_find8
    import encoder83_pkg::*;
(
    input  logic [REQ_W-1:0] i_vec,
    input  logic [SEL_W-1:0] i_start,
    output logic             o_found,
    output logic [SEL_W-1:0] o_idx
);

    logic [SEL_W-1:0] k;

    // Walk offsets from farthest to nearest so the nearest hit is kept.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        k       = '0;
        for (int i = REQ_W - 1; i >= 0; i--) begin
            k = i_start + SEL_W'(i);
            if (i_vec[k]) begin
                o_found = 1'b1;
                o_idx   = k;
            end
        end
    end

endmodule

// File: rtl/encoder83_pend.sv
// Registered 8-to-3 priority encoder with edge-captured pending requests.
// Define ENCODER83_PEND_ROUND_ROBIN_EN for round-robin selection.
module encoder83_pend
    import encoder83_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REQ_W-1:0] i_req,
    input  logic             i_opt,
    input  logic             i_ack,
    output logic             o_valid,
    output logic [SEL_W-1:0] o_sel,
    output logic [REQ_W-1:0] o_pend,
    output logic             o_ovf
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [REQ_W-1:0] pend_q, pend_d;
    logic [REQ_W-1:0] r_q, r_d;
    logic             ovf_q, ovf_d;

    logic [REQ_W-1:0] rise;
    logic [REQ_W-1:0] clr;
    logic [REQ_W-1:0] pick_vec;
    logic [SEL_W-1:0] pick_start;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             valid;
    logic             ack_fire;

    assign valid    = (state_q == ST_PRESENT);
    assign ack_fire = valid & i_ack;

    always_comb begin
        r_d    = i_opt ? i_req : ~i_req;
        rise   = r_d & ~r_q;
        clr    = ack_fire ? onehot8(sel_q) : '0;
        pend_d = (pend_q & ~clr) | rise;
        ovf_d  = ovf_q | (|(rise & pend_q & ~clr));
    end

`ifdef ENCODER83_PEND_ROUND_ROBIN_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (ack_fire) begin
            ptr_d = sel_q + SEL_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // The next pick must already honour the pointer advanced by this ack.
    assign pick_start = ptr_d;
`else
    assign pick_start = '0;
`endif

    // IDLE loads from the registered pending set; an ack loads from nxt.
    assign pick_vec = valid ? pend_d : pend_q;

    prio_find8 u_prio (
        .i_vec   (pick_vec),
        .i_start (pick_start),
        .o_found (pick_found),
        .o_idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (i_ack) begin
                    if (pick_found) begin
                        sel_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            pend_q  <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_valid = valid;
    assign o_sel   = sel_q;
    assign o_pend  = pend_q;
    assign o_ovf   = ovf_q;

endmodule
